// File: rtl/stopwatch_ctrl.sv
// Pushbutton front end for the stopwatch: synchronizes and debounces three buttons,
// runs the IDLE/RUN/PAUSED control FSM and emits a lap-index write on every pause.
module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SYNC_STAGES     = 2,
    parameter int LAP_SLOTS       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic       btn_stop,
    output logic       start,
    output logic       pause,
    output logic       stop,
    output logic       mem_write,
    output logic [7:0] mem_address,
    output logic [7:0] mem_data_write,
    output logic [1:0] run_state
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [7:0]        LAP_LAST = 8'(LAP_SLOTS - 1);
    localparam int                B_START  = 0;
    localparam int                B_PAUSE  = 1;
    localparam int                B_STOP   = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_t;

    logic [2:0]             w_btn_raw;
    logic [SYNC_STAGES-1:0] r_sync [3];
    logic [CNT_W-1:0]       r_cnt  [3];
    logic [2:0]             r_stable;
    logic [2:0]             r_stable_d;
    logic [2:0]             w_press;

    assign w_btn_raw = {btn_stop, btn_pause, btn_start};

    // The counter runs only while the synchronized input disagrees with the
    // stable level; the last counted cycle commits the new level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < 3; b++) begin
                r_sync[b] <= '0;
                r_cnt[b]  <= '0;
            end
            r_stable   <= '0;
            r_stable_d <= '0;
        end else begin
            r_stable_d <= r_stable;
            for (int b = 0; b < 3; b++) begin
                r_sync[b] <= {r_sync[b][SYNC_STAGES-2:0], w_btn_raw[b]};
                if (r_sync[b][SYNC_STAGES-1] == r_stable[b]) begin
                    r_cnt[b] <= '0;
                end else if (r_cnt[b] == CNT_LAST) begin
                    r_stable[b] <= r_sync[b][SYNC_STAGES-1];
                    r_cnt[b]    <= '0;
                end else begin
                    r_cnt[b] <= r_cnt[b] + CNT_ONE;
                end
            end
        end
    end

    assign w_press = r_stable & ~r_stable_d;

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_lap;
    logic [7:0] w_lap_next;
    logic [7:0] r_data;
    logic [7:0] w_data_next;
    logic       r_start;
    logic       r_pause;
    logic       r_stop;
    logic       r_write;
    logic       w_stop_next;
    logic       w_write_next;

    // Only the highest-priority press in a cycle is acted on; the rest are dropped.
    always_comb begin
        w_next_state = r_state;
        w_lap_next   = r_lap;
        w_data_next  = r_data;
        w_stop_next  = 1'b0;
        w_write_next = 1'b0;
        if (w_press[B_STOP]) begin
            w_next_state = ST_IDLE;
            w_stop_next  = 1'b1;
            w_lap_next   = 8'd0;
            w_data_next  = 8'd0;
        end else if (w_press[B_PAUSE]) begin
            case (r_state)
                ST_RUN: begin
                    w_next_state = ST_PAUSED;
                    w_write_next = 1'b1;
                    w_data_next  = r_lap;
                    w_lap_next   = (r_lap == LAP_LAST) ? 8'd0 : r_lap + 8'd1;
                end
                ST_PAUSED: w_next_state = ST_RUN;
                default:   w_next_state = r_state;
            endcase
        end else if (w_press[B_START]) begin
            case (r_state)
                ST_IDLE, ST_PAUSED: w_next_state = ST_RUN;
                default:            w_next_state = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_lap   <= 8'd0;
            r_data  <= 8'd0;
            r_start <= 1'b0;
            r_pause <= 1'b0;
            r_stop  <= 1'b0;
            r_write <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_lap   <= w_lap_next;
            r_data  <= w_data_next;
            r_start <= (w_next_state != ST_IDLE);
            r_pause <= (w_next_state == ST_PAUSED);
            r_stop  <= w_stop_next;
            r_write <= w_write_next;
        end
    end

    assign start          = r_start;
    assign pause          = r_pause;
    assign stop           = r_stop;
    assign mem_write      = r_write;
    assign mem_address    = 8'd0;
    assign mem_data_write = r_data;
    assign run_state      = r_state;

endmodule
